// File: rtl/spawn_scheduler.sv
// Spawn scheduler: times character spawns, sanitises generator words and
// arbitrates the slot-table write port between spawns and (higher-priority) kills.
module spawn_scheduler #(
  parameter int unsigned SLOTS  = 8,
  parameter int unsigned SLOT_W = 3,
  parameter int unsigned PERIOD = 25000000,
  parameter int unsigned X_MAX  = 624,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [23:0]       gen_ch,
  input  logic [SLOTS-1:0]  slot_busy,
  input  logic              kill_req,
  input  logic [SLOT_W-1:0] kill_slot,
  output logic              wr_en,
  output logic [SLOT_W-1:0] wr_slot,
  output logic [23:0]       wr_data,
  output logic              gen_take,
  output logic              busy,
  output logic [CNT_W-1:0]  spawn_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int unsigned     TMR_W  = $clog2(PERIOD);
  localparam logic [TMR_W-1:0] RELOAD = TMR_W'(PERIOD - 1);
  localparam logic [9:0]       XLIM   = 10'(X_MAX);

  typedef enum logic [1:0] {IDLE, COUNT, PICK, WRITE} state_t;

  state_t              state_q, state_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [23:0]         word_q, word_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [CNT_W-1:0]    spawn_cnt_q, spawn_cnt_d;
  logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
  logic [23:0]         san;
  logic                free_found;
  logic [SLOT_W-1:0]   free_idx;

  // Lowest free slot; iterating downward lets index 0 win.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = int'(SLOTS) - 1; i >= 0; i--) begin
      if (!slot_busy[i]) begin
        free_found = 1'b1;
        free_idx   = SLOT_W'(i);
      end
    end
  end

  // Force valid, nonzero speed, top row, and in-bounds x.
  always_comb begin
    san        = gen_ch;
    san[23]    = 1'b1;
    if (gen_ch[22:19] == 4'd0) san[22:19] = 4'd1;
    san[18:10] = '0;
    if (gen_ch[9:0] > XLIM) san[9:0] = XLIM;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      word_q      <= '0;
      slot_q      <= '0;
      spawn_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      word_q      <= word_d;
      slot_q      <= slot_d;
      spawn_cnt_q <= spawn_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    word_d      = word_q;
    slot_d      = slot_q;
    spawn_cnt_d = spawn_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = COUNT;
          timer_d = RELOAD;
        end
      end
      COUNT: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (timer_q == '0) begin
          state_d = PICK;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      PICK: begin
        word_d = san;
        slot_d = free_idx;
        if (free_found) begin
          state_d = WRITE;
        end else begin
          if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);
          timer_d = RELOAD;
          state_d = enable ? COUNT : IDLE;
        end
      end
      WRITE: begin
        // A concurrent kill owns the port; the spawn waits here.
        if (!kill_req) begin
          if (spawn_cnt_q != '1) spawn_cnt_d = spawn_cnt_q + CNT_W'(1);
          timer_d = RELOAD;
          state_d = enable ? COUNT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Write port: kill is zero-latency and wins; nothing is issued while in reset.
  always_comb begin
    wr_en    = 1'b0;
    wr_slot  = '0;
    wr_data  = '0;
    gen_take = 1'b0;
    busy     = 1'b0;
    if (!rst) begin
      gen_take = (state_q == PICK);
      busy     = (state_q == PICK) || (state_q == WRITE);
      if (kill_req) begin
        wr_en   = 1'b1;
        wr_slot = kill_slot;
      end else if (state_q == WRITE) begin
        wr_en   = 1'b1;
        wr_slot = slot_q;
        wr_data = word_q;
      end
    end
  end

  assign spawn_cnt = spawn_cnt_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_spawn_scheduler.sv
// Scoreboard bench for spawn_scheduler with PERIOD=4: expected writes are queued
// by the stimulus process and matched by a negedge monitor, including their cycle.
module tb_spawn_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [23:0] gen_ch;
  logic [7:0]  slot_busy;
  logic        kill_req;
  logic [2:0]  kill_slot;
  logic        wr_en;
  logic [2:0]  wr_slot;
  logic [23:0] wr_data;
  logic        gen_take;
  logic        busy;
  logic [15:0] spawn_cnt;
  logic [15:0] drop_cnt;

  spawn_scheduler #(
    .SLOTS(8), .SLOT_W(3), .PERIOD(4), .X_MAX(624), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .gen_ch(gen_ch),
    .slot_busy(slot_busy), .kill_req(kill_req), .kill_slot(kill_slot),
    .wr_en(wr_en), .wr_slot(wr_slot), .wr_data(wr_data),
    .gen_take(gen_take), .busy(busy),
    .spawn_cnt(spawn_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [2:0]  slot;
    logic [23:0] data;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic at(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_wr(input int c, input logic [2:0] s, input logic [23:0] d);
    exp_t x;
    x.cyc  = c;
    x.slot = s;
    x.data = d;
    q.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_at(input int c, input string name, input logic [31:0] act_unused,
                        input logic [31:0] exp);
    // Cycle-argument sanity helper; sampling is done by the tasks above.
    if (c < 0) $display("bad cycle %0d %s %0h %0h", c, name, act_unused, exp);
  endtask

  // Monitor: every write strobe must match the next queued expectation.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: cyc=%0d slot=%0d data=%h", cyc, wr_slot, wr_data);
      end else begin
        e = q.pop_front();
        if (cyc != e.cyc || wr_slot !== e.slot || wr_data !== e.data) begin
          bad++;
          $display("FAIL write: got cyc=%0d slot=%0d data=%h want cyc=%0d slot=%0d data=%h",
                   cyc, wr_slot, wr_data, e.cyc, e.slot, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; gen_ch = '0; slot_busy = '0;
    kill_req = 1'b0; kill_slot = '0;

    at(1);
    @(negedge clk);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_slot", 32'(wr_slot), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_gen_take", 32'(gen_take), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_spawn_cnt", 32'(spawn_cnt), 0);
    chk("rst_drop_cnt", 32'(drop_cnt), 0);

    // Enable seen at edge 3; writes at 8 and 14 (PERIOD+2 apart).
    at(2);
    rst = 1'b0; enable = 1'b1; slot_busy = 8'h00; gen_ch = 24'h1A0C45;
    expect_wr(8, 3'd0, 24'h980045);   // valid=1 speed=3 y=0 x=69
    expect_wr(14, 3'd0, 24'h980045);
    at(7);
    @(negedge clk);
    chk("pick_gen_take", 32'(gen_take), 1);
    chk("pick_busy", 32'(busy), 1);
    at(15);
    @(negedge clk);
    chk("spawn_cnt_2", 32'(spawn_cnt), 2);

    // Lowest free slot is 3; speed 0 -> 1, y cleared, x 700 clamps to 624.
    at(15);
    gen_ch = {1'b0, 4'd0, 9'd5, 10'd700};
    slot_busy = 8'b0000_0111;
    expect_wr(20, 3'd3, 24'h880270);

    // Full table at PICK (cycle 25): dropped, timer reloads.
    at(21);
    slot_busy = 8'hFF;
    at(25);
    @(negedge clk);
    chk("drop_gen_take", 32'(gen_take), 1);
    at(26);
    slot_busy = 8'hDF;
    gen_ch = 24'hF80270;              // already legal, x at the limit
    @(negedge clk);
    chk("drop_cnt_1", 32'(drop_cnt), 1);
    chk("drop_gen_take_off", 32'(gen_take), 0);
    chk("drop_busy_off", 32'(busy), 0);

    // Kill held through three WRITE cycles, spawn lands on the fourth.
    expect_wr(31, 3'd5, 24'h0);
    expect_wr(32, 3'd5, 24'h0);
    expect_wr(33, 3'd5, 24'h0);
    expect_wr(34, 3'd5, 24'hF80270);
    at(31);
    kill_req = 1'b1; kill_slot = 3'd5;
    at(34);
    kill_req = 1'b0;
    @(negedge clk);
    chk("kill_spawn_cnt_before", 32'(spawn_cnt), 3);
    at(35);
    slot_busy = 8'h00;
    @(negedge clk);
    chk("kill_spawn_cnt_after", 32'(spawn_cnt), 4);

    // Reset asserted while in WRITE (cycle 40): no write, everything cleared.
    at(40);
    rst = 1'b1;
    @(negedge clk);
    chk("rstw_wr_en", 32'(wr_en), 0);
    chk("rstw_busy", 32'(busy), 0);
    at(41);
    rst = 1'b0; gen_ch = 24'h000000;
    @(negedge clk);
    chk("post_rst_wr_en", 32'(wr_en), 0);
    chk("post_rst_wr_data", 32'(wr_data), 0);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_gen_take", 32'(gen_take), 0);
    chk("post_rst_spawn_cnt", 32'(spawn_cnt), 0);
    chk("post_rst_drop_cnt", 32'(drop_cnt), 0);
    expect_wr(47, 3'd0, 24'h880000);  // fresh full period from IDLE

    // Disable in COUNT: idle for 20 cycles, then restart full period.
    at(49);
    enable = 1'b0;
    at(55);
    @(negedge clk);
    chk("disabled_busy", 32'(busy), 0);
    at(70);
    enable = 1'b1;
    expect_wr(76, 3'd0, 24'h880000);

    // Disable during WRITE: write completes, then idle; kill still served in IDLE.
    at(76);
    enable = 1'b0;
    at(80);
    kill_req = 1'b1; kill_slot = 3'd2;
    expect_wr(80, 3'd2, 24'h0);
    at(81);
    kill_req = 1'b0;
    at(90);
    @(negedge clk);
    chk("end_busy", 32'(busy), 0);
    chk("end_spawn_cnt", 32'(spawn_cnt), 2);
    chk("end_drop_cnt", 32'(drop_cnt), 0);
    chk("queue_empty", 32'(q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
